// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package div_pkg;

  localparam int DEF_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep or restore, and emit the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           bit_in,
  input  logic [WIDTH:0] dvs_mag,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // rem_in < dvs_mag <= 2^(WIDTH-1), so the shifted value never overflows WIDTH+1 bits
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], bit_in};
    trial   = {1'b0, shifted} - {1'b0, dvs_mag};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (quotient -> LO, remainder -> HI), one quotient bit per clock
// on magnitudes with sign fix-up; done arrives WIDTH+1 cycles after start, 1 cycle on /0.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic [WIDTH:0]   dvd_ext, dvs_ext, dvd_abs, dvs_abs;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .dvs_mag (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    // Magnitudes are taken in WIDTH+1 bits so |most-negative| is representable
    dvd_ext = {dividend[WIDTH-1], dividend};
    dvs_ext = {divisor[WIDTH-1], divisor};
    dvd_abs = dividend[WIDTH-1] ? (~dvd_ext + 1'b1) : dvd_ext;
    dvs_abs = divisor[WIDTH-1]  ? (~dvs_ext + 1'b1) : dvs_ext;
    q_mag   = {dvd_q[WIDTH-2:0], step_q};
    r_mag   = step_rem[WIDTH-1:0];

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_neg_d = dividend[WIDTH-1];
          dvd_d   = dvd_abs[WIDTH-1:0];
          dvs_d   = dvs_abs;
          rem_d   = '0;
          cnt_d   = '0;
          if (divisor == '0) begin
            quot_d  = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FIX;
          end else begin
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = q_mag;
        cnt_d = cnt_q + 1'b1;
        // Sign fix-up folds into the last iteration so done lands in the FIX cycle
        if (cnt_q == LAST) begin
          quot_d  = q_neg_q ? (~q_mag + 1'b1) : q_mag;
          rmd_d   = r_neg_q ? (~r_mag + 1'b1) : r_mag;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: vector table plus hand-written handshake/reset sequences.
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_signed_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Standalone iteration instance, 4-bit operands
  logic [4:0] st_rem_in, st_dvs, st_rem_out;
  logic       st_bit, st_q;

  div_step #(.WIDTH(4)) u_step_tb (
    .rem_in  (st_rem_in),
    .bit_in  (st_bit),
    .dvs_mag (st_dvs),
    .rem_out (st_rem_out),
    .q_bit   (st_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input logic dbz, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge (cycle 1)
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  // Counts cycles until done (bounded); busy must be high every cycle before done and low with it
  task automatic wait_done(input int lat0, output int lat, output int busy_err);
    lat = lat0;
    busy_err = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_err++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy) busy_err++;
  endtask

  initial begin
    int lat, berr, nodone;
    logic [31:0] q_hold;

    add_vec(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
    add_vec(-32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0, 33);
    add_vec(32'd100,        -32'sd7,        -32'sd14,       32'd2,          1'b0, 33);
    add_vec(-32'sd100,      -32'sd7,        32'd14,         -32'sd2,        1'b0, 33);
    add_vec(32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1);
    add_vec(32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33);
    add_vec(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33);
    add_vec(32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 33);
    add_vec(32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33);
    add_vec(-32'sd7,        32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1);
    add_vec(32'h8000_0000,  32'd7,          32'hEDB6_DB6E,  32'hFFFF_FFFE,  1'b0, 33);

    // div_step unit checks
    st_rem_in = 5'd3; st_bit = 1'b1; st_dvs = 5'd5; #1;
    chk("step 7-5", {st_q, st_rem_out}, {1'b1, 5'd2});
    st_rem_in = 5'd1; st_bit = 1'b0; st_dvs = 5'd5; #1;
    chk("step 2<5", {st_q, st_rem_out}, {1'b0, 5'd2});
    st_rem_in = 5'd7; st_bit = 1'b1; st_dvs = 5'd8; #1;
    chk("step 15-8", {st_q, st_rem_out}, {1'b1, 5'd7});

    // Reset state
    #10;
    chk("reset outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(1, lat, berr);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d busy", i), berr, 0);
      chk($sformatf("v%0d quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d div_by_zero", i), div_by_zero, vecs[i].dbz);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d hold", i), {done, div_by_zero, quotient, remainder},
          {1'b0, vecs[i].dbz, vecs[i].q, vecs[i].r});
    end

    // start while busy is ignored
    launch(32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(11, lat, berr);
    chk("ignore latency", lat, 33);
    chk("ignore result", {quotient, remainder}, {32'd14, 32'd2});

    // start raised in the done cycle is taken one cycle later
    start = 1'b1; dividend = -32'sd50; divisor = 32'd5;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1, lat, berr);
    chk("back2back latency", lat, 33);
    chk("back2back busy", berr, 0);
    chk("back2back result", {quotient, remainder}, {32'hFFFF_FFF6, 32'd0});
    @(posedge clk);
    #1;

    // Asynchronous reset mid-operation
    launch(32'd100, 32'd7);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    chk("busy before clr", busy, 1'b1);
    clr = 1'b0;
    #1;
    chk("clr async outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    nodone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nodone++;
    end
    chk("no done after clr", nodone, 0);
    launch(32'd81, 32'd9);
    wait_done(1, lat, berr);
    chk("post-clr latency", lat, 33);
    chk("post-clr result", {quotient, remainder}, {32'd9, 32'd0});
    q_hold = quotient;
    @(posedge clk);
    #1;
    chk("post-clr hold", {done, quotient}, {1'b0, q_hold});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
